// File: rtl/aes_pkg.sv
// Shared AES sequencing types and constants, common to the round sequencer and key generator.
package aes_pkg;

   localparam int NUM_ROUNDS     = 10;
   localparam int ADDR_W         = 4;
   localparam int KEY_ADDR_FIRST = 0;
   localparam int KEY_ADDR_LAST  = NUM_ROUNDS;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ROUND,
      FINAL,
      HOLD
   } seq_state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Round counter and key-address generator: counts rounds up while the key address
// walks up (encrypt) or down (decrypt) from the end selected at load time.
module aes_round_counter #(
   parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
   parameter int ADDR_W     = aes_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic              load_up,
   input  logic              inc,
   output logic [ADDR_W-1:0] read_addr,
   output logic              last_round
);
   import aes_pkg::*;

   localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(KEY_ADDR_FIRST);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_ROUNDS);
   localparam logic [ADDR_W-1:0] CNT_TC     = ADDR_W'(NUM_ROUNDS - 1);
   localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

   logic [ADDR_W-1:0] cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              up_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg  <= '0;
         addr_reg <= '0;
         up_reg   <= 1'b1;
      end else if (clr) begin
         cnt_reg  <= '0;
         addr_reg <= '0;
      end else if (load) begin
         cnt_reg  <= '0;
         addr_reg <= load_up ? ADDR_FIRST : ADDR_LAST;
         up_reg   <= load_up;
      end else if (inc) begin
         cnt_reg  <= cnt_reg + ONE;
         addr_reg <= up_reg ? addr_reg + ONE : addr_reg - ONE;
      end
   end

   // Flag seen while the last middle round is current, so the next step is FINAL.
   assign last_round = (cnt_reg == CNT_TC);
   assign read_addr  = addr_reg;

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences one AES block through load, middle rounds and final round, then hands the
// result to the TX FIFO; every output is registered from the next-state decode.
module aes_round_sequencer #(
   parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
   parameter int ADDR_W     = aes_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_encrypt,
   input  logic              keys_ready,
   input  logic              abort,
   input  logic              tx_fifo_full,
   output logic [ADDR_W-1:0] read_addr,
   output logic              dp_load,
   output logic              dp_round_en,
   output logic              dp_final,
   output logic              tx_enq,
   output logic              data_done,
   output logic              busy,
   output logic              start_err
);
   import aes_pkg::*;

   seq_state_t state_reg, state_next;
   logic dp_load_reg, dp_round_en_reg, dp_final_reg, tx_enq_reg;
   logic data_done_reg, busy_reg, start_err_reg;
   logic tx_enq_next, data_done_next, start_err_next;
   logic cnt_clr, cnt_load, cnt_inc, last_round;

   aes_round_counter #(
      .NUM_ROUNDS(NUM_ROUNDS),
      .ADDR_W    (ADDR_W)
   ) u_round_counter (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .load      (cnt_load),
      .load_up   (is_encrypt),
      .inc       (cnt_inc),
      .read_addr (read_addr),
      .last_round(last_round)
   );

   // A cycle carrying data_done is always the last busy cycle: an abort parks the
   // block in HOLD for that one pulse so busy drops on the following cycle.
   always_comb begin
      state_next     = state_reg;
      tx_enq_next    = 1'b0;
      data_done_next = 1'b0;
      start_err_next = 1'b0;
      cnt_clr        = 1'b0;
      cnt_load       = 1'b0;
      cnt_inc        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && keys_ready) begin
               state_next = INIT;
               cnt_load   = 1'b1;
            end else if (start) begin
               start_err_next = 1'b1;
            end
         end
         INIT, ROUND: begin
            if (abort) begin
               state_next     = HOLD;
               data_done_next = 1'b1;
            end else begin
               state_next = (state_reg == ROUND && last_round) ? FINAL : ROUND;
               cnt_inc    = 1'b1;
            end
         end
         FINAL: begin
            state_next     = HOLD;
            data_done_next = abort || !tx_fifo_full;
            tx_enq_next    = !abort && !tx_fifo_full;
         end
         HOLD: begin
            if (data_done_reg) begin
               state_next = IDLE;
               cnt_clr    = 1'b1;
            end else begin
               data_done_next = abort || !tx_fifo_full;
               tx_enq_next    = !abort && !tx_fifo_full;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         dp_load_reg     <= 1'b0;
         dp_round_en_reg <= 1'b0;
         dp_final_reg    <= 1'b0;
         tx_enq_reg      <= 1'b0;
         data_done_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         start_err_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         dp_load_reg     <= (state_next == INIT);
         dp_round_en_reg <= (state_next == ROUND);
         dp_final_reg    <= (state_next == FINAL);
         tx_enq_reg      <= tx_enq_next;
         data_done_reg   <= data_done_next;
         busy_reg        <= (state_next != IDLE);
         start_err_reg   <= start_err_next;
      end
   end

   assign dp_load     = dp_load_reg;
   assign dp_round_en = dp_round_en_reg;
   assign dp_final    = dp_final_reg;
   assign tx_enq      = tx_enq_reg;
   assign data_done   = data_done_reg;
   assign busy        = busy_reg;
   assign start_err   = start_err_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: a position-based block model checked every
// cycle, plus hand-computed cycle/address expectations per scenario.
module tb_aes_round_sequencer;

   localparam int NR = 10;

   logic       clk = 1'b0;
   logic       rst, start, is_encrypt, keys_ready, abort, tx_fifo_full;
   logic [3:0] read_addr;
   logic       dp_load, dp_round_en, dp_final, tx_enq, data_done, busy, start_err;

   int n_checks = 0;
   int n_fail   = 0;

   aes_round_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_encrypt  (is_encrypt),
      .keys_ready  (keys_ready),
      .abort       (abort),
      .tx_fifo_full(tx_fifo_full),
      .read_addr   (read_addr),
      .dp_load     (dp_load),
      .dp_round_en (dp_round_en),
      .dp_final    (dp_final),
      .tx_enq      (tx_enq),
      .data_done   (data_done),
      .busy        (busy),
      .start_err   (start_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model: block position since acceptance ----------------
   bit       m_valid = 0, m_active = 0, m_exit = 0, m_enc = 1;
   int       m_pos = 0;
   bit       e_load, e_round, e_final, e_enq, e_done, e_busy, e_err, addr_chk;
   int       e_addr;

   always @(posedge clk) begin
      e_err = 0; e_enq = 0; e_done = 0;
      if (rst) begin
         m_valid = 1; m_active = 0; m_exit = 0; m_pos = 0; m_enc = 1;
      end else if (!m_active) begin
         if (start && keys_ready) begin
            m_active = 1; m_pos = 1; m_enc = is_encrypt;
         end else if (start) begin
            e_err = 1;
         end
      end else if (m_exit) begin
         m_active = 0; m_exit = 0;
      end else if (abort) begin
         m_exit = 1; e_done = 1;
      end else begin
         if (m_pos >= NR + 1 && !tx_fifo_full) begin
            e_enq = 1; e_done = 1; m_exit = 1;
         end
         m_pos++;
      end
      e_busy  = m_active;
      e_load  = m_active && !m_exit && m_pos == 1;
      e_round = m_active && !m_exit && m_pos >= 2 && m_pos <= NR;
      e_final = m_active && !m_exit && m_pos == NR + 1;
      addr_chk = !m_active || e_load || e_round || e_final;
      if (!m_active)    e_addr = 0;
      else if (e_load)  e_addr = m_enc ? 0 : NR;
      else if (e_round) e_addr = m_enc ? m_pos - 1 : NR - (m_pos - 1);
      else              e_addr = m_enc ? NR : 0;
   end

   task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         cmp("busy",        {3'b0, busy},        {3'b0, e_busy});
         cmp("dp_load",     {3'b0, dp_load},     {3'b0, e_load});
         cmp("dp_round_en", {3'b0, dp_round_en}, {3'b0, e_round});
         cmp("dp_final",    {3'b0, dp_final},    {3'b0, e_final});
         cmp("tx_enq",      {3'b0, tx_enq},      {3'b0, e_enq});
         cmp("data_done",   {3'b0, data_done},   {3'b0, e_done});
         cmp("start_err",   {3'b0, start_err},   {3'b0, e_err});
         if (addr_chk) cmp("read_addr", read_addr, 4'(e_addr));
         if (data_done === 1'b1) $display("txn: block end at %0t tx_enq=%0b", $time, tx_enq);
         if (start_err === 1'b1) $display("txn: start rejected at %0t", $time);
      end
   end

   // ---------------- directed scenarios with per-cycle traces ----------------
   logic       tr_load[0:31], tr_round[0:31], tr_final[0:31], tr_enq[0:31];
   logic       tr_done[0:31], tr_busy[0:31], tr_err[0:31];
   logic [3:0] tr_addr[0:31];
   int         full_lo, full_hi, abort_at, restart_at, rst_at, n_enq;
   bit         flip_dir;

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_sched();
      full_lo = 0; full_hi = -1; abort_at = -1; restart_at = -1; rst_at = -1; flip_dir = 0;
   endtask

   // Start is sampled at edge 0; trace index c is the cycle after edge c-1.
   task automatic run_block(input bit enc, input bit keys, input int ncyc);
      keys_ready = keys; is_encrypt = enc; start = 1'b1;
      tick();
      start = 1'b0;
      n_enq = 0;
      for (int c = 1; c <= ncyc; c++) begin
         tr_load[c] = dp_load;  tr_round[c] = dp_round_en; tr_final[c] = dp_final;
         tr_enq[c]  = tx_enq;   tr_done[c]  = data_done;   tr_busy[c]  = busy;
         tr_err[c]  = start_err; tr_addr[c] = read_addr;
         if (tx_enq === 1'b1) n_enq++;
         tx_fifo_full = (c >= full_lo && c <= full_hi);
         abort = (c == abort_at);
         start = (c == restart_at);
         rst   = (c == rst_at);
         if (flip_dir) is_encrypt = ~enc;
         tick();
      end
      abort = 1'b0; start = 1'b0; rst = 1'b0; tx_fifo_full = 1'b0;
      clear_sched();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_encrypt = 1'b1; keys_ready = 1'b0;
      abort = 1'b0; tx_fifo_full = 1'b0;
      clear_sched();
      repeat (3) tick();
      chk("reset_busy", busy, 0);
      chk("reset_addr", read_addr, 0);
      chk("reset_enables", dp_load + dp_round_en + dp_final + tx_enq, 0);
      rst = 1'b0;
      tick();

      // encrypt, FIFO empty
      run_block(1'b1, 1'b1, 14);
      chk("enc_load_c1", tr_load[1], 1);
      chk("enc_addr_c1", tr_addr[1], 0);
      chk("enc_round_c2", tr_round[2], 1);
      chk("enc_addr_c6", tr_addr[6], 5);
      chk("enc_round_c10", tr_round[10], 1);
      chk("enc_final_c11", tr_final[11], 1);
      chk("enc_addr_c11", tr_addr[11], 10);
      chk("enc_enq_c12", tr_enq[12], 1);
      chk("enc_done_c12", tr_done[12], 1);
      chk("enc_busy_c12", tr_busy[12], 1);
      chk("enc_busy_c13", tr_busy[13], 0);

      // decrypt, direction input toggled mid-block
      flip_dir = 1;
      run_block(1'b0, 1'b1, 14);
      chk("dec_addr_c1", tr_addr[1], 10);
      chk("dec_addr_c3", tr_addr[3], 8);
      chk("dec_addr_c11", tr_addr[11], 0);
      chk("dec_enq_c12", tr_enq[12], 1);
      chk("dec_busy_c13", tr_busy[13], 0);

      // back-pressure: full sampled at edges 10..18
      full_lo = 10; full_hi = 18;
      run_block(1'b1, 1'b1, 23);
      chk("bp_enq_c12", tr_enq[12], 0);
      chk("bp_enq_c20", tr_enq[20], 1);
      chk("bp_enq_count", n_enq, 1);
      chk("bp_busy_c20", tr_busy[20], 1);
      chk("bp_busy_c21", tr_busy[21], 0);

      // reject: keys not ready
      run_block(1'b1, 1'b0, 3);
      chk("rej_err_c1", tr_err[1], 1);
      chk("rej_busy_c1", tr_busy[1], 0);
      chk("rej_err_c2", tr_err[2], 0);

      // start while busy is ignored
      restart_at = 5;
      run_block(1'b1, 1'b1, 16);
      chk("restart_enq_count", n_enq, 1);
      chk("restart_enq_c12", tr_enq[12], 1);
      chk("restart_err_c6", tr_err[6], 0);

      // abort mid-rounds
      abort_at = 6;
      run_block(1'b1, 1'b1, 10);
      chk("abort_done_c7", tr_done[7], 1);
      chk("abort_busy_c7", tr_busy[7], 1);
      chk("abort_busy_c8", tr_busy[8], 0);
      chk("abort_enq_count", n_enq, 0);

      // abort in HOLD on the cycle the FIFO frees up
      full_lo = 10; full_hi = 14; abort_at = 15;
      run_block(1'b0, 1'b1, 18);
      chk("hold_abort_done_c15", tr_done[15], 0);
      chk("hold_abort_done_c16", tr_done[16], 1);
      chk("hold_abort_enq_count", n_enq, 0);
      chk("hold_abort_busy_c17", tr_busy[17], 0);

      // reset mid-block, then a clean block
      rst_at = 4;
      run_block(1'b1, 1'b1, 6);
      chk("rst_addr_c4", tr_addr[4], 3);
      chk("rst_busy_c5", tr_busy[5], 0);
      chk("rst_round_c5", tr_round[5], 0);
      chk("rst_addr_c5", tr_addr[5], 0);
      chk("rst_done_c5", tr_done[5], 0);
      run_block(1'b1, 1'b1, 14);
      chk("post_rst_enq_c12", tr_enq[12], 1);
      chk("post_rst_busy_c13", tr_busy[13], 0);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
